// File: rtl/codec_pkg.sv
// Shared widths and pipeline stage records for the encode/inject/decode scheduler.
package codec_pkg;

    localparam int DATA_W = 6;
    localparam int CODE_W = 19;

    typedef struct packed {
        logic              v;
        logic              id;
        logic [DATA_W-1:0] b;
        logic [CODE_W-1:0] e;
    } s1_t;

    typedef struct packed {
        logic              v;
        logic              id;
        logic [DATA_W-1:0] b;
        logic [CODE_W-1:0] e;
        logic [CODE_W-1:0] c;
    } s2_t;

    typedef struct packed {
        logic              v;
        logic              id;
        logic [DATA_W-1:0] b;
        logic [CODE_W-1:0] qx;
    } s3_t;

endpackage

// File: rtl/codec_pipe_sched_if.sv
// Requester, codec-side and response signals of the shared codec pipeline.
interface codec_pipe_sched_if
    import codec_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_b;
    logic [CODE_W-1:0] req0_e;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_b;
    logic [CODE_W-1:0] req1_e;
    logic [DATA_W-1:0] enc_b;
    logic [CODE_W-1:0] enc_c;
    logic [CODE_W-1:0] dec_qx;
    logic [DATA_W-1:0] dec_q;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_q;
    logic [DATA_W-1:0] rsp_b;
    logic              rsp_mismatch;
    logic [CNT_W-1:0]  done_cnt;
    logic [CNT_W-1:0]  mismatch_cnt;

    modport slave (
        input  req0_valid, req0_b, req0_e, req1_valid, req1_b, req1_e,
        input  enc_c, dec_q, rsp_ready,
        output req0_ready, req1_ready, enc_b, dec_qx,
        output rsp_valid, rsp_id, rsp_q, rsp_b, rsp_mismatch, done_cnt, mismatch_cnt
    );

    modport master (
        output req0_valid, req0_b, req0_e, req1_valid, req1_b, req1_e,
        output enc_c, dec_q, rsp_ready,
        input  req0_ready, req1_ready, enc_b, dec_qx,
        input  rsp_valid, rsp_id, rsp_q, rsp_b, rsp_mismatch, done_cnt, mismatch_cnt
    );
endinterface

// File: rtl/codec_pipe_sched_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester other than the last winner is granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_r;

    // Grant decode; nothing is granted while disabled.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_r ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end else begin
            gnt = 2'b00;
        end
    end

    // Remember the winner; reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r <= 1'b1;
        end else if (|gnt) begin
            last_r <= gnt[1];
        end else begin
            last_r <= last_r;
        end
    end
endmodule

// File: rtl/codec_pipe_sched.sv
// Round-robin scheduler sharing one encode -> error-inject -> decode pipeline between two requesters.
module codec_pipe_sched
    import codec_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                reset,
    codec_pipe_sched_if.slave  bus
);
    s1_t              s1_r;
    s2_t              s2_r;
    s3_t              s3_r;
    logic [CNT_W-1:0] done_cnt_r;
    logic [CNT_W-1:0] mismatch_cnt_r;
    logic             adv_s;
    logic [1:0]       gnt_s;
    logic             fire_s;
    logic             mism_s;

    // Ready is suppressed during reset so nothing looks accepted while state is being cleared.
    assign adv_s  = (!s3_r.v || bus.rsp_ready) && !reset;
    assign fire_s = s3_r.v && bus.rsp_ready;
    assign mism_s = (bus.dec_q != s3_r.b);

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (adv_s),
        .req   ({bus.req1_valid, bus.req0_valid}),
        .gnt   (gnt_s)
    );

    assign bus.req0_ready   = gnt_s[0];
    assign bus.req1_ready   = gnt_s[1];
    assign bus.enc_b        = s1_r.b;
    assign bus.dec_qx       = s3_r.qx;
    assign bus.rsp_valid    = s3_r.v;
    assign bus.rsp_id       = s3_r.id;
    assign bus.rsp_b        = s3_r.b;
    assign bus.rsp_q        = bus.dec_q;
    assign bus.rsp_mismatch = mism_s;
    assign bus.done_cnt     = done_cnt_r;
    assign bus.mismatch_cnt = mismatch_cnt_r;

    // Pipeline stages shift together on adv; a cycle without a grant injects a cleared bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r <= '0;
            s2_r <= '0;
            s3_r <= '0;
        end else if (adv_s) begin
            if (gnt_s[1]) begin
                s1_r <= '{v: 1'b1, id: 1'b1, b: bus.req1_b, e: bus.req1_e};
            end else if (gnt_s[0]) begin
                s1_r <= '{v: 1'b1, id: 1'b0, b: bus.req0_b, e: bus.req0_e};
            end else begin
                s1_r <= '0;
            end
            s2_r <= '{v: s1_r.v, id: s1_r.id, b: s1_r.b, e: s1_r.e, c: bus.enc_c};
            s3_r <= '{v: s2_r.v, id: s2_r.id, b: s2_r.b, qx: s2_r.c ^ s2_r.e};
        end else begin
            s1_r <= s1_r;
            s2_r <= s2_r;
            s3_r <= s3_r;
        end
    end

    // Saturating delivery and mismatch counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_cnt_r     <= '0;
            mismatch_cnt_r <= '0;
        end else begin
            if (fire_s && (done_cnt_r != '1)) begin
                done_cnt_r <= done_cnt_r + CNT_W'(1);
            end else begin
                done_cnt_r <= done_cnt_r;
            end
            if (fire_s && mism_s && (mismatch_cnt_r != '1)) begin
                mismatch_cnt_r <= mismatch_cnt_r + CNT_W'(1);
            end else begin
                mismatch_cnt_r <= mismatch_cnt_r;
            end
        end
    end
endmodule

// File: tb/tb_codec_pipe_sched.sv
// Directed bench for codec_pipe_sched; the codec is a triple-repetition code plus parity bit.
module tb_codec_pipe_sched;
    import codec_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    codec_pipe_sched_if #(.CNT_W(16)) bus ();

    codec_pipe_sched #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Codeword = {parity, b, b, b}; decoding takes a per-bit majority of the three copies.
    function automatic logic [18:0] enc_f(input logic [5:0] b);
        return {^b, b, b, b};
    endfunction

    function automatic logic [5:0] dec_f(input logic [18:0] c);
        logic [5:0] q;
        for (int i = 0; i < 6; i++) begin
            q[i] = (c[i] & c[i+6]) | (c[i] & c[i+12]) | (c[i+6] & c[i+12]);
        end
        return q;
    endfunction

    assign bus.enc_c = enc_f(bus.enc_b);
    assign bus.dec_q = dec_f(bus.dec_qx);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_b = 6'h3F;
        bus.req0_e = 19'h00000;
        bus.req1_valid = 1'b1;
        bus.req1_b = 6'h3F;
        bus.req1_e = 19'h00000;
        bus.rsp_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_r0_ready", 32'(bus.req0_ready), 32'h0);
        chk("rst_r1_ready", 32'(bus.req1_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_enc_b", 32'(bus.enc_b), 32'h0);
        chk("rst_dec_qx", 32'(bus.dec_qx), 32'h0);
        chk("rst_done", 32'(bus.done_cnt), 32'h0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("post_rst_rsp_id", 32'(bus.rsp_id), 32'h0);
        chk("post_rst_rsp_b", 32'(bus.rsp_b), 32'h0);
        chk("post_rst_mis_cnt", 32'(bus.mismatch_cnt), 32'h0);

        // Single word, no error
        bus.req0_valid = 1'b1; bus.req0_b = 6'h2A; bus.req0_e = 19'h00000;
        #1;
        chk("t1_r0_ready", 32'(bus.req0_ready), 32'h1);
        chk("t1_r1_ready", 32'(bus.req1_ready), 32'h0);
        step();
        bus.req0_valid = 1'b0;
        chk("t1_enc_b", 32'(bus.enc_b), 32'h2A);
        step();
        chk("t1_valid_early", 32'(bus.rsp_valid), 32'h0);
        step();
        chk("t1_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t1_id", 32'(bus.rsp_id), 32'h0);
        chk("t1_dec_qx", 32'(bus.dec_qx), 32'h6AAAA);
        chk("t1_q", 32'(bus.rsp_q), 32'h2A);
        chk("t1_mis", 32'(bus.rsp_mismatch), 32'h0);
        step();
        chk("t1_valid_after", 32'(bus.rsp_valid), 32'h0);
        chk("t1_done", 32'(bus.done_cnt), 32'h1);

        // Single-bit error is corrected
        bus.req1_valid = 1'b1; bus.req1_b = 6'h15; bus.req1_e = 19'h01000;
        #1;
        chk("t2_r1_ready", 32'(bus.req1_ready), 32'h1);
        step();
        bus.req1_valid = 1'b0;
        step();
        step();
        chk("t2_id", 32'(bus.rsp_id), 32'h1);
        chk("t2_dec_qx", 32'(bus.dec_qx), 32'h54555);
        chk("t2_q", 32'(bus.rsp_q), 32'h15);
        chk("t2_mis", 32'(bus.rsp_mismatch), 32'h0);
        step();
        chk("t2_done", 32'(bus.done_cnt), 32'h2);

        // Two errors in different data bits are both corrected
        bus.req0_valid = 1'b1; bus.req0_b = 6'h15; bus.req0_e = 19'h00081;
        step();
        bus.req0_valid = 1'b0;
        step();
        step();
        chk("t3_q", 32'(bus.rsp_q), 32'h15);
        chk("t3_mis", 32'(bus.rsp_mismatch), 32'h0);
        step();
        chk("t3_mis_cnt", 32'(bus.mismatch_cnt), 32'h0);

        // Two errors in the same data bit outvote the good copy
        bus.req1_valid = 1'b1; bus.req1_b = 6'h15; bus.req1_e = 19'h00041;
        step();
        bus.req1_valid = 1'b0;
        step();
        step();
        chk("t4_q", 32'(bus.rsp_q), 32'h14);
        chk("t4_mis", 32'(bus.rsp_mismatch), 32'h1);
        step();
        chk("t4_mis_cnt", 32'(bus.mismatch_cnt), 32'h1);
        chk("t4_done", 32'(bus.done_cnt), 32'h4);

        // Contention right after reset: grants alternate starting with requester 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.req0_b = 6'h01; bus.req0_e = 19'h00000;
        bus.req1_b = 6'h3E; bus.req1_e = 19'h00000;
        for (int j = 0; j < 10; j++) begin
            bus.req0_valid = (j < 6);
            bus.req1_valid = (j < 6);
            #1;
            if (j < 6) begin
                chk($sformatf("t5_r0_ready_%0d", j), 32'(bus.req0_ready), 32'((j % 2) == 0));
                chk($sformatf("t5_r1_ready_%0d", j), 32'(bus.req1_ready), 32'((j % 2) == 1));
            end
            if (j >= 3 && j < 9) begin
                chk($sformatf("t5_valid_%0d", j), 32'(bus.rsp_valid), 32'h1);
                chk($sformatf("t5_id_%0d", j), 32'(bus.rsp_id), 32'((j - 3) % 2));
                chk($sformatf("t5_b_%0d", j), 32'(bus.rsp_b), ((j - 3) % 2 == 0) ? 32'h01 : 32'h3E);
            end else begin
                chk($sformatf("t5_valid_%0d", j), 32'(bus.rsp_valid), 32'h0);
            end
            step();
        end
        chk("t5_done", 32'(bus.done_cnt), 32'h6);

        // Backpressure: 5 words from requester 0, consumer stalls cycles 3..6
        begin
            int idx;
            idx = 0;
            for (int j = 0; j < 13; j++) begin
                bus.req0_valid = (idx < 5);
                bus.req0_b = 6'(8'h10 + idx);
                bus.rsp_ready = !(j >= 3 && j <= 6);
                #1;
                chk($sformatf("t6_ready_%0d", j), 32'(bus.req0_ready),
                    32'((j <= 2) || (j == 7) || (j == 8)));
                if (j >= 3 && j <= 11) begin
                    chk($sformatf("t6_valid_%0d", j), 32'(bus.rsp_valid), 32'h1);
                    chk($sformatf("t6_b_%0d", j), 32'(bus.rsp_b), (j <= 7) ? 32'h10 : 32'(32'h10 + j - 7));
                    chk($sformatf("t6_q_%0d", j), 32'(bus.rsp_q), (j <= 7) ? 32'h10 : 32'(32'h10 + j - 7));
                end else begin
                    chk($sformatf("t6_valid_%0d", j), 32'(bus.rsp_valid), 32'h0);
                end
                if (bus.req0_ready) idx++;
                step();
            end
            bus.req0_valid = 1'b0;
            bus.rsp_ready = 1'b1;
            chk("t6_done", 32'(bus.done_cnt), 32'd11);
        end

        // Reset with three words in flight drops them all
        bus.req1_valid = 1'b1; bus.req1_b = 6'h2D; bus.req1_e = 19'h00000;
        step();
        step();
        step();
        bus.rsp_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("t7_r1_ready_rst", 32'(bus.req1_ready), 32'h0);
        step();
        chk("t7_valid", 32'(bus.rsp_valid), 32'h0);
        chk("t7_done", 32'(bus.done_cnt), 32'h0);
        chk("t7_mis_cnt", 32'(bus.mismatch_cnt), 32'h0);
        reset = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk($sformatf("t7_stale_%0d", j), 32'(bus.rsp_valid), 32'h0);
            step();
        end
        chk("t7_done_end", 32'(bus.done_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/codec_pipe_sched.md
# codec_pipe_sched

Round-robin scheduler that shares one 3-stage encode → error-inject → decode pipeline between two requesters. It owns the stage registers, drives the combinational `encoder` and `decoder` instances through dedicated ports, and performs the 19-bit error XOR internally. Each result is tagged with its requester, checked against the original 6-bit data, and returned on a single response port with backpressure.

## Interface
Parameters:
- CNT_W, 16: width of the saturating result and mismatch counters.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req0_valid  in  1  requester 0 offers a word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req0_b  in  6  requester 0 data.
- req0_e  in  19  requester 0 error pattern.
- req1_valid, req1_ready, req1_b, req1_e: the same for requester 1.
- enc_b  out  6  to `encoder` input; equals stage-1 data register.
- enc_c  in  19  codeword from `encoder`.
- dec_qx  out  19  to `decoder` input; equals stage-3 corrupted-codeword register.
- dec_q  in  6  decoded data from `decoder`.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  requester that issued the word.
- rsp_q  out  6  decoded data (dec_q).
- rsp_b  out  6  original data.
- rsp_mismatch  out  1  rsp_q != rsp_b.
- done_cnt  out  CNT_W  responses delivered (saturating).
- mismatch_cnt  out  CNT_W  delivered responses with rsp_mismatch=1 (saturating).

## Operation
- Stage 1 (S1) register holds {v1, id1, b1, e1}. enc_b = b1.
- Stage 2 (S2) register holds {v2, id2, b2, e2, c2}. c2 is captured from enc_c.
- Stage 3 (S3) register holds {v3, id3, b3, qx3}. qx3 is captured as c2 ^ e2. dec_qx = qx3.
- Response outputs: rsp_valid = v3, rsp_id = id3, rsp_b = b3, rsp_q = dec_q.
- adv = !v3 || rsp_ready. When adv is 1, all stages shift together. When adv is 0, all stages hold and no request is granted.
- Arbitration:
  - Eligible requesters are those with valid asserted, and only while adv=1.
  - With one eligible requester, it is granted.
  - With two eligible requesters, the one not equal to `last` is granted. `last` updates on every grant.
  - req*_ready is asserted only for the granted requester and is combinational from req*_valid, adv and `last`.
- With no grant while adv=1, a bubble (v1=0) enters S1.
- Counters increment only on rsp_valid && rsp_ready and saturate at all-ones. mismatch_cnt additionally requires rsp_mismatch.
- Reset clears v1, v2, v3, all data and tag registers, `last`=1 (requester 0 wins the first tie), done_cnt and mismatch_cnt.
- Outputs during reset and on the first cycle after it: rsp_valid=0, req*_ready=0 while reset is high, enc_b=0, dec_qx=0, rsp_id=0, rsp_b=0, counters=0.
- Reset mid-operation drops every in-flight word. No response is emitted for it.

## Timing
- A word accepted at posedge N (valid&&ready in cycle N-1) appears on rsp_valid after posedge N+2 when there are no stalls. Latency is 3 cycles from the acceptance cycle.
- Throughput is one word per cycle.
- Each cycle with v3=1 and rsp_ready=0 adds exactly one cycle of latency to every in-flight word. No word is lost or duplicated.
- rsp_* stays stable while rsp_valid=1 and rsp_ready=0.
- The consumer may deassert rsp_ready at any time.
- Requesters must hold valid and their data until ready. The block does not require this for correctness, because data is sampled only on the grant cycle.
- enc_c and dec_q are combinational. Each sees one full cycle from its register.

## Structure
- Shared package `codec_pkg` holds:
  - DATA_W=6 and CODE_W=19.
  - The stage-record typedefs.
- One sub-module is natural: `rr_arb2`, a 2-way round-robin arbiter with a `last` pointer and an enable (adv).
- The encoder, decoder and XOR datapath are not duplicated inside this block.

## Test plan
- Single word: req0 b=6'h2A, e=0, rsp_ready=1 → rsp_valid 3 cycles after acceptance, rsp_id=0, rsp_q=6'h2A, rsp_mismatch=0, done_cnt=1.
- Single-bit error: req1 b=6'h15, e=19'h01000 → rsp_q=6'h15, rsp_mismatch=0, since a single-bit error is corrected.
- Double-bit error: e=19'h00081 → rsp_mismatch matches (dec_q != b) and mismatch_cnt increments by exactly that.
- Contention: both requesters valid for 6 cycles after reset → grants alternate 0,1,0,1,0,1, and rsp_id follows the same sequence 3 cycles later.
- Backpressure: stream 5 words with rsp_ready low for 4 cycles while v3=1 → req*_ready=0 during the stall, rsp outputs are held, all 5 words are delivered in order with no loss.
- Reset mid-flight: assert reset with 3 words in flight → next cycle rsp_valid=0, counters=0, and no stale response appears afterward.
